dcache_tagv_ctrl: RTL and testbench
===================================

// Module: dcache_tagv_ctrl
// PURPOSE
//  Sequencer for the 2-way Dcache tag/valid array: accepts one lookup at a time, drives the read/compare ports, and on a miss picks a victim way.
//  Issues the line refill request to memory, then writes the new tag into the victim way.
//  Sits between the LSU request port and the TagV array / memory read channel.
// PARAMETERS
//  ADDR_WIDTH    4   set-index width; 2**ADDR_WIDTH sets
//  TAG_WIDTH     25  tag width; equals TagV data width
//  OFFSET_WIDTH  3   line-offset width; mem_rd_addr = TAG+ADDR+OFFSET bits
//  WAY           2   ways; fixed at 2, other values unsupported
// PORTS
//  clk           in   1            clock, all state on rising edge
//  rstn          in   1            asynchronous active-low reset
//  req_valid     in   1            lookup request
//  req_ready     out  1            =1 only in IDLE
//  req_index     in   ADDR_WIDTH   set index
//  req_tag       in   TAG_WIDTH    tag
//  TagV_addr_read    out ADDR_WIDTH   array read index
//  TagV_din_compare  out TAG_WIDTH    tag under compare
//  hit           in   WAY          per-way hit from array
//  TagV_addr_write   out ADDR_WIDTH   write index; also selects valid bit used by hit
//  TagV_din_write    out TAG_WIDTH    tag to write
//  TagV_we       out  WAY          one-hot way write strobe
//  mem_rd_req    out  1            refill request, held until accepted
//  mem_rd_ready  in   1            memory accepts request
//  mem_rd_addr   out  TAG+ADDR+OFFSET   {tag,index,OFFSET_WIDTH'b0}
//  mem_rd_done   in   1            line returned (1-cycle pulse)
//  resp_valid    out  1            response, held until resp_ready
//  resp_ready    in   1            consumer accepts response
//  resp_hit      out  1            1=hit, 0=filled after miss
//  resp_way      out  1            way holding the line
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; TagV_we=0, mem_rd_req=0, resp_valid=0, resp_hit=0, resp_way=0; all regs and LRU bits 0.
//  IDLE: TagV_addr_read=req_index combinationally; on req_valid&req_ready latch index/tag -> LOOKUP.
//  LOOKUP (bram data valid): TagV_addr_write=latched index, TagV_din_compare=latched tag.
//    hit!=0 -> RESP, resp_hit=1, resp_way=lowest set hit bit (both set: way0).
//    hit==0 -> MISS, victim latched.
//  MISS: mem_rd_req=1; mem_rd_addr stable; on mem_rd_ready -> REFILL_WAIT.
//  REFILL_WAIT: mem_rd_req=0; on mem_rd_done -> REFILL_WRITE.
//  REFILL_WRITE: exactly one cycle; TagV_we=one-hot(victim), TagV_din_write=tag, TagV_addr_write=index -> RESP, resp_hit=0, resp_way=victim.
//  RESP: resp_valid=1 with stable fields; on resp_ready -> IDLE.
//  Latency: accept at cycle 0 -> hit resp_valid at cycle 2. Miss adds MISS + wait + 1 write cycle.
//  TagV_we=0 in every state except REFILL_WRITE; no new request is accepted before RESP handshake completes.
//  mem_rd_ready and mem_rd_done outside their states: ignored. mem_rd_done same cycle as mem_rd_ready: ignored (done must follow accept).
//  Async reset mid-miss: return to IDLE immediately and drop the outstanding request; later mem_rd_done is ignored.
//  TagV valid bits are not cleared by this block.
// CONFIGURATION
//  DCACHE_LRU_EN defined: per-set LRU bit. The way not used last is the victim. Updated on hit (LRU<=~hit way) and on refill (LRU<=~victim).
//  Undefined: victim=1-bit global counter, toggles on every refill write; no per-set storage.
// TESTING
//  reset, req idx=3 tag=0x1ABCDE, hit=2'b10 -> resp_valid at cycle 2, resp_hit=1, resp_way=1, TagV_we never set.
//  miss idx=5 tag=0x000123, mem_rd_ready after 3 cycles, done 4 cycles later -> mem_rd_addr=(0x000123<<7)|(5<<3); one-cycle TagV_we=2'b01; resp_hit=0, way 0.
//  LRU_EN: second miss to idx=5 -> TagV_we=2'b10. Then hit way1 and miss -> victim way0.
//  hit=2'b11 -> resp_way=0. resp_ready held 0 for 5 cycles -> resp fields stable, req_ready=0.
//  rstn low in REFILL_WAIT, then mem_rd_done pulse -> state IDLE, TagV_we stays 0, no resp_valid.
//  req_valid asserted during MISS/RESP -> not accepted until IDLE, accepted request latched unchanged.

Source files
------------

// File: rtl/dcache_tagv_ctrl_if.sv
// Bus bundle for the 2-way Dcache tag/valid sequencer.
// It carries the LSU request, the TagV array ports, the memory refill
// request channel and the response channel.
// The master modport is the sequencer's view. The slave modport is the view
// of the surrounding LSU, array and memory.
interface dcache_tagv_ctrl_if #(
    parameter int ADDR_WIDTH   = 4,
    parameter int TAG_WIDTH    = 25,
    parameter int OFFSET_WIDTH = 3,
    parameter int WAY          = 2
);
    // LSU request
    logic                                      req_valid;
    logic                                      req_ready;
    logic [ADDR_WIDTH-1:0]                     req_index;
    logic [TAG_WIDTH-1:0]                      req_tag;
    // TagV array
    logic [ADDR_WIDTH-1:0]                     TagV_addr_read;
    logic [TAG_WIDTH-1:0]                      TagV_din_compare;
    logic [WAY-1:0]                            hit;
    logic [ADDR_WIDTH-1:0]                     TagV_addr_write;
    logic [TAG_WIDTH-1:0]                      TagV_din_write;
    logic [WAY-1:0]                            TagV_we;
    // memory refill request
    logic                                      mem_rd_req;
    logic                                      mem_rd_ready;
    logic [TAG_WIDTH+ADDR_WIDTH+OFFSET_WIDTH-1:0] mem_rd_addr;
    logic                                      mem_rd_done;
    // response
    logic                                      resp_valid;
    logic                                      resp_ready;
    logic                                      resp_hit;
    logic                                      resp_way;

    modport master (
        input  req_valid, req_index, req_tag, hit, mem_rd_ready, mem_rd_done, resp_ready,
        output req_ready, TagV_addr_read, TagV_din_compare, TagV_addr_write,
               TagV_din_write, TagV_we, mem_rd_req, mem_rd_addr,
               resp_valid, resp_hit, resp_way
    );

    modport slave (
        output req_valid, req_index, req_tag, hit, mem_rd_ready, mem_rd_done, resp_ready,
        input  req_ready, TagV_addr_read, TagV_din_compare, TagV_addr_write,
               TagV_din_write, TagV_we, mem_rd_req, mem_rd_addr,
               resp_valid, resp_hit, resp_way
    );
endinterface

// File: rtl/dcache_tagv_ctrl.sv
// Sequencer for the 2-way Dcache tag/valid array.
// It handles one lookup at a time. On a miss it picks a victim way, issues
// the line refill to memory, and then writes the new tag into the victim way.
// Build option DCACHE_LRU_EN: when defined, each set keeps an LRU bit. When
// undefined, a single global bit that toggles on each refill picks the victim.
// Module parameters must match the interface parameters.
module dcache_tagv_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int TAG_WIDTH    = 25,
    parameter int OFFSET_WIDTH = 3,
    parameter int WAY          = 2
) (
    input  logic                clk,
    input  logic                rstn,
    dcache_tagv_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        LOOKUP       = 3'd1,
        MISS         = 3'd2,
        REFILL_WAIT  = 3'd3,
        REFILL_WRITE = 3'd4,
        RESP         = 3'd5
    } state_t;

    state_t                 stateReg;
    state_t                 stateNext;
    logic [ADDR_WIDTH-1:0]  indexReg;
    logic [TAG_WIDTH-1:0]   tagReg;
    logic                   victimReg;
    logic                   respHitReg;
    logic                   respWayReg;
    logic                   victimPick;
    logic                   anyHit;
    logic                   hitWay;
    logic [WAY-1:0]         weNext;

    // Way 0 takes priority when both ways report a hit.
    assign anyHit = (bus.hit != '0);
    assign hitWay = ~bus.hit[0];

`ifdef DCACHE_LRU_EN
    // Each set keeps one bit that names the way not used most recently.
    logic [2**ADDR_WIDTH-1:0] lruReg;

    assign victimPick = lruReg[indexReg];

    // Point the set's LRU bit away from the way just hit or just refilled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lruReg <= '0;
        end else if (stateReg == LOOKUP && anyHit) begin
            lruReg[indexReg] <= ~hitWay;
        end else if (stateReg == REFILL_WRITE) begin
            lruReg[indexReg] <= ~victimReg;
        end
    end
`else
    // A single bit shared by all sets alternates the victim on every refill.
    logic victimCtrReg;

    assign victimPick = victimCtrReg;

    // Toggle the shared victim bit each time a refill writes a tag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            victimCtrReg <= 1'b0;
        end else if (stateReg == REFILL_WRITE) begin
            victimCtrReg <= ~victimCtrReg;
        end
    end
`endif

    // State register. Reset abandons any outstanding refill.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Latch the accepted request, the chosen victim and the response fields.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            indexReg   <= '0;
            tagReg     <= '0;
            victimReg  <= 1'b0;
            respHitReg <= 1'b0;
            respWayReg <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (bus.req_valid) begin
                        indexReg <= bus.req_index;
                        tagReg   <= bus.req_tag;
                    end
                end
                LOOKUP: begin
                    if (anyHit) begin
                        respHitReg <= 1'b1;
                        respWayReg <= hitWay;
                    end else begin
                        victimReg <= victimPick;
                    end
                end
                REFILL_WRITE: begin
                    respHitReg <= 1'b0;
                    respWayReg <= victimReg;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic plus the state-dependent outputs.
    // The array read address follows req_index while idle so that the
    // registered read data is ready in LOOKUP.
    always_comb begin
        stateNext          = stateReg;
        weNext             = '0;
        bus.req_ready      = 1'b0;
        bus.mem_rd_req     = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.TagV_addr_read = indexReg;
        case (stateReg)
            IDLE: begin
                bus.req_ready      = 1'b1;
                bus.TagV_addr_read = bus.req_index;
                if (bus.req_valid) stateNext = LOOKUP;
            end
            LOOKUP: begin
                stateNext = anyHit ? RESP : MISS;
            end
            MISS: begin
                bus.mem_rd_req = 1'b1;
                if (bus.mem_rd_ready) stateNext = REFILL_WAIT;
            end
            REFILL_WAIT: begin
                if (bus.mem_rd_done) stateNext = REFILL_WRITE;
            end
            REFILL_WRITE: begin
                weNext[victimReg] = 1'b1;
                stateNext         = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.TagV_we          = weNext;
    assign bus.TagV_din_compare = tagReg;
    assign bus.TagV_addr_write  = indexReg;
    assign bus.TagV_din_write   = tagReg;
    assign bus.mem_rd_addr      = {tagReg, indexReg, {OFFSET_WIDTH{1'b0}}};
    assign bus.resp_hit         = respHitReg;
    assign bus.resp_way         = respWayReg;

endmodule

// File: tb/tb_dcache_tagv_ctrl.sv
// Testbench for dcache_tagv_ctrl.
// A reference model predicts the response and the victim way from the
// replacement rules: the way not used last, or an alternating refill counter.
module tb_dcache_tagv_ctrl;
    localparam int AW = 4;
    localparam int TW = 25;
    localparam int OW = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dcache_tagv_ctrl_if #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW), .OFFSET_WIDTH(OW), .WAY(2)) bus();

    dcache_tagv_ctrl #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW), .OFFSET_WIDTH(OW), .WAY(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state.
    // lastUsed is the way most recently hit or filled in each set.
    // refillCount is the number of refills completed since reset.
    bit lastUsed [16];
    int refillCount;

    function automatic logic modelVictim(input logic [AW-1:0] idx);
`ifdef DCACHE_LRU_EN
        return ~lastUsed[idx];
`else
        return (refillCount % 2) == 1;
`endif
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 16; i++) lastUsed[i] = 1'b1;
        refillCount = 0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.req_valid    = 1'b0;
        bus.req_index    = '0;
        bus.req_tag      = '0;
        bus.hit          = 2'b00;
        bus.mem_rd_ready = 1'b0;
        bus.mem_rd_done  = 1'b0;
        bus.resp_ready   = 1'b0;
    endtask

    // One full lookup. The bench acts as LSU, array and memory.
    // Stall lengths are given in cycles. When noise is set, the bench drives
    // inputs that the design must ignore.
    task automatic runTxn(input logic [AW-1:0] idx, input logic [TW-1:0] tag, input logic [1:0] hv,
                          input int rdyDly, input int doneDly, input int respDly, input bit noise);
        logic                 expHit;
        logic                 expWay;
        logic [1:0]           expWe;
        logic [TW+AW+OW-1:0]  expAddr;
        expAddr = {tag, idx, 3'b000};
        expHit  = (hv != 2'b00);
        expWay  = expHit ? ~hv[0] : modelVictim(idx);
        expWe   = expWay ? 2'b10 : 2'b01;

        bus.req_valid = 1'b1; bus.req_index = idx; bus.req_tag = tag; bus.hit = hv;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL offer_req_ready got=%b exp=1", bus.req_ready); end
        checks++; if (bus.TagV_addr_read !== idx) begin failures++; $display("FAIL addr_read got=%0d exp=%0d", bus.TagV_addr_read, idx); end
        cyc();
        // LOOKUP
        bus.req_valid = noise;
        if (noise) begin bus.req_index = AW'($urandom_range(0, 15)); bus.req_tag = TW'($urandom); end
        #1;
        checks++; if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.TagV_we !== 2'b00) begin
            failures++; $display("FAIL lookup_ctrl rdy=%b rv=%b we=%b exp 0/0/00", bus.req_ready, bus.resp_valid, bus.TagV_we); end
        checks++; if (bus.TagV_addr_write !== idx || bus.TagV_din_compare !== tag) begin
            failures++; $display("FAIL lookup_cmp got idx=%0d tag=%h exp idx=%0d tag=%h", bus.TagV_addr_write, bus.TagV_din_compare, idx, tag); end
        cyc();
        if (noise) bus.hit = 2'($urandom_range(0, 3));
        if (!expHit) begin
            #1;
            checks++; if (bus.mem_rd_req !== 1'b1 || bus.mem_rd_addr !== expAddr || bus.TagV_we !== 2'b00) begin
                failures++; $display("FAIL miss_req req=%b addr=%h we=%b exp 1 %h 00", bus.mem_rd_req, bus.mem_rd_addr, bus.TagV_we, expAddr); end
            for (int k = 0; k < rdyDly; k++) begin
                bus.mem_rd_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                cyc(); #1;
                checks++; if (bus.mem_rd_req !== 1'b1 || bus.mem_rd_addr !== expAddr || bus.TagV_we !== 2'b00) begin
                    failures++; $display("FAIL miss_hold req=%b addr=%h we=%b exp 1 %h 00", bus.mem_rd_req, bus.mem_rd_addr, bus.TagV_we, expAddr); end
            end
            bus.mem_rd_ready = 1'b1;
            bus.mem_rd_done  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            cyc();
            // REFILL_WAIT
            bus.mem_rd_ready = 1'b0; bus.mem_rd_done = 1'b0;
            #1;
            checks++; if (bus.mem_rd_req !== 1'b0 || bus.TagV_we !== 2'b00 || bus.resp_valid !== 1'b0) begin
                failures++; $display("FAIL wait_entry req=%b we=%b rv=%b exp 0 00 0", bus.mem_rd_req, bus.TagV_we, bus.resp_valid); end
            for (int k = 0; k < doneDly; k++) begin
                bus.mem_rd_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                cyc();
                bus.mem_rd_ready = 1'b0;
                #1;
                checks++; if (bus.mem_rd_req !== 1'b0 || bus.TagV_we !== 2'b00 || bus.resp_valid !== 1'b0) begin
                    failures++; $display("FAIL wait_hold req=%b we=%b rv=%b exp 0 00 0", bus.mem_rd_req, bus.TagV_we, bus.resp_valid); end
            end
            bus.mem_rd_done = 1'b1;
            cyc();
            // REFILL_WRITE
            bus.mem_rd_done = 1'b0;
            #1;
            checks++; if (bus.TagV_we !== expWe || bus.TagV_din_write !== tag || bus.TagV_addr_write !== idx) begin
                failures++; $display("FAIL refill_write we=%b tag=%h idx=%0d exp %b %h %0d", bus.TagV_we, bus.TagV_din_write, bus.TagV_addr_write, expWe, tag, idx); end
            checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL refill_rv got=%b exp=0", bus.resp_valid); end
            cyc();
        end
        // RESP
        #1;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_hit !== expHit || bus.resp_way !== expWay) begin
            failures++; $display("FAIL resp rv=%b hit=%b way=%b exp 1 %b %b", bus.resp_valid, bus.resp_hit, bus.resp_way, expHit, expWay); end
        checks++; if (bus.TagV_we !== 2'b00 || bus.req_ready !== 1'b0) begin
            failures++; $display("FAIL resp_ctrl we=%b rdy=%b exp 00 0", bus.TagV_we, bus.req_ready); end
        for (int k = 0; k < respDly; k++) begin
            if (noise) bus.mem_rd_done = 1'($urandom_range(0, 1));
            cyc(); #1;
            checks++; if (bus.resp_valid !== 1'b1 || bus.resp_hit !== expHit || bus.resp_way !== expWay || bus.req_ready !== 1'b0) begin
                failures++; $display("FAIL resp_stall rv=%b hit=%b way=%b rdy=%b exp 1 %b %b 0", bus.resp_valid, bus.resp_hit, bus.resp_way, bus.req_ready, expHit, expWay); end
        end
        bus.resp_ready = 1'b1;
        cyc();
        bus.resp_ready = 1'b0; bus.req_valid = 1'b0; bus.hit = 2'b00; bus.mem_rd_done = 1'b0;
        #1;
        checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++; $display("FAIL resp_done rv=%b rdy=%b exp 0 1", bus.resp_valid, bus.req_ready); end

        lastUsed[idx] = expWay;
        if (!expHit) refillCount++;
        $display("txn idx=%0d tag=%h hit=%b -> resp_hit=%b way=%0d lastUsed=%0d", idx, tag, hv, expHit, expWay, lastUsed[idx]);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idleInputs();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.req_ready !== 1'b1 || bus.TagV_we !== 2'b00 || bus.mem_rd_req !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl rdy=%b we=%b mreq=%b exp 1 00 0", bus.req_ready, bus.TagV_we, bus.mem_rd_req); end
        checks++; if (bus.resp_valid !== 1'b0 || bus.resp_hit !== 1'b0 || bus.resp_way !== 1'b0) begin
            failures++; $display("FAIL reset_resp rv=%b hit=%b way=%b exp 0 0 0", bus.resp_valid, bus.resp_hit, bus.resp_way); end
        checks++; if (bus.mem_rd_addr !== '0 || bus.TagV_din_compare !== '0) begin
            failures++; $display("FAIL reset_regs addr=%h cmp=%h exp 0 0", bus.mem_rd_addr, bus.TagV_din_compare); end
        rstn = 1'b1;
        modelReset();
        cyc();
        $display("txn reset");
    endtask

    task automatic test_hit();
        runTxn(4'd3, 25'h1ABCDE, 2'b10, 0, 0, 0, 1'b0);
    endtask

    task automatic test_miss();
        runTxn(4'd5, 25'h000123, 2'b00, 3, 3, 0, 1'b0);
    endtask

    task automatic test_lru();
        runTxn(4'd5, 25'h0A5A5A, 2'b00, 1, 2, 1, 1'b0);
        runTxn(4'd5, 25'h0A5A5A, 2'b10, 0, 0, 0, 1'b0);
        runTxn(4'd5, 25'h1F0F0F, 2'b00, 0, 1, 0, 1'b0);
    endtask

    task automatic test_both_hit_stall();
        runTxn(4'd9, 25'h0BEEF1, 2'b11, 0, 0, 5, 1'b1);
    endtask

    task automatic test_reset_mid_miss();
        bus.req_valid = 1'b1; bus.req_index = 4'd7; bus.req_tag = 25'h0CAFE; bus.hit = 2'b00;
        cyc();
        bus.req_valid = 1'b0;
        cyc();
        bus.mem_rd_ready = 1'b1;
        cyc();
        bus.mem_rd_ready = 1'b0;
        cyc();
        checks++; if (bus.mem_rd_req !== 1'b0 || bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
            failures++; $display("FAIL pre_reset_wait mreq=%b rdy=%b rv=%b exp 0 0 0", bus.mem_rd_req, bus.req_ready, bus.resp_valid); end
        rstn = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1 || bus.mem_rd_req !== 1'b0 || bus.TagV_we !== 2'b00) begin
            failures++; $display("FAIL async_reset rdy=%b mreq=%b we=%b exp 1 0 00", bus.req_ready, bus.mem_rd_req, bus.TagV_we); end
        cyc();
        rstn = 1'b1;
        modelReset();
        bus.mem_rd_done = 1'b1;
        cyc();
        bus.mem_rd_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (bus.TagV_we !== 2'b00 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
                failures++; $display("FAIL after_reset we=%b rv=%b rdy=%b exp 00 0 1", bus.TagV_we, bus.resp_valid, bus.req_ready); end
            cyc();
        end
        $display("txn reset during refill wait");
    endtask

    task automatic test_random();
        logic [AW-1:0] idx;
        logic [1:0]    hv;
        for (int n = 0; n < 40; n++) begin
            idx = AW'($urandom_range(0, 3) + (($urandom_range(0, 3) == 0) ? 4 : 0));
            hv  = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(1, 3));
            runTxn(idx, TW'($urandom), hv, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        idleInputs();
        test_reset();
        test_hit();
        test_miss();
        test_lru();
        test_both_hit_stall();
        test_reset_mid_miss();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
